mul_rr_scheduler: RTL
=====================

Name: mul_rr_scheduler

Overview:
- Shares one iterative 16x16 unsigned shift-add multiply engine among NREQ requesters, using round-robin arbitration.
- Each requester presents operands on a valid/ready handshake.
- The block computes one bit per clock and returns the 2*WIDTH product, tagged with the requester id, on a single response port with valid/ready backpressure.
- It sits between multiple datapath clients and the multiplier resource, replacing per-client multipliers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width; the product is 2*WIDTH.
- IDW (localparam), max(1, clog2(NREQ)), width of the requester id.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has operands pending.
- req_ready  output  NREQ  bit i: requester i's operands are accepted this cycle.
- req_a  input  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same slicing as req_a.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_res.
- rsp_res  output  2*WIDTH  unsigned product A*B.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- One clock. Reset is synchronous and active-high: on a clk edge with reset=1, all state clears regardless of the current state.
  - State goes to IDLE; rr pointer goes to 0.
  - rsp_valid=0, rsp_id=0, rsp_res=0, busy=0, req_ready=0, bit counter=0.
- An operation in progress when reset is applied is discarded; no response is issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - The arbiter picks the first i with req_valid[i]=1, scanning from the rr pointer upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - req_ready is combinational, one-hot on the winner, and only in IDLE; it is all-zero in every other state.
  - A transfer happens when req_valid[i] and req_ready[i] are both high. On that edge:
    - latch A into the multiplicand and B into the multiplier register;
    - clear the accumulator and latch id=i;
    - set ptr=(i+1) mod NREQ and go to RUN.
  - With no req_valid bits set, stay in IDLE and leave ptr unchanged.
- RUN:
  - Exactly WIDTH cycles, one per multiplier bit, LSB first.
  - Each cycle: if the current multiplier bit is 1, add the multiplicand shifted left by the bit index into the 2*WIDTH accumulator. Carries are never lost.
  - After the WIDTH-th cycle: copy the accumulator to rsp_res, set rsp_valid=1 and go to DONE.
- DONE:
  - rsp_valid, rsp_res and rsp_id stay stable until a cycle with rsp_ready=1.
  - On that edge: rsp_valid=0 and go to IDLE. rsp_res and rsp_id hold their last values.
  - No new request is accepted while in DONE.
- Latency: accept at cycle T gives rsp_valid high from cycle T+WIDTH+1. With rsp_ready held high, accept-to-accept spacing is WIDTH+2 cycles.
- Requester-side rules:
  - Operands are sampled only on the accept edge; later changes to req_a/req_b do not affect the operation in flight.
  - A requester that drops req_valid before it is granted loses nothing.
- Boundaries:
  - All NREQ valid continuously: grants rotate 0,1,...,NREQ-1,0.
  - Only one requester valid: it is granted every time, whatever the pointer value.
  - rsp_ready held low indefinitely: the block stalls in DONE and busy stays 1.
  - Operand 0 or 0xFFFF: computed normally, with the full WIDTH-cycle latency in the base build.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: if the latched A==0 or B==0 on the accept edge, skip RUN and go straight to DONE with rsp_res=0. rsp_valid then rises at T+1.
- Not defined: every operation spends WIDTH cycles in RUN. The zero-detect logic is absent.

Test Plan:
- Single request: reset pulse, then requester 0 drives A=0xDAD6, B=0x27CD -> req_ready[0] for 1 cycle; rsp_valid at T+17 with rsp_res=0x2205D75E, rsp_id=0.
- Max operands: requester 2 drives A=0xFFFF, B=0xFFFF -> rsp_res=0xFFFE0001, rsp_id=2. Also A=1, B=0x8000 -> 0x00008000.
- Round-robin fairness: all 4 requesters continuously valid, each with A=i+1, B=0x0100, rsp_ready=1 -> grant order 0,1,2,3,0; results 0x100, 0x200, 0x300, 0x400; accepts every 18 cycles.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_res and rsp_id stable, req_ready all 0. Raise rsp_ready -> IDLE next cycle, then the next accept.
- Reset mid-operation: assert reset 5 cycles into RUN -> next edge gives busy=0, rsp_valid=0, ptr=0. No response ever appears for the aborted operation; the next request from requester 3 completes correctly.
- Zero operand: A=0, B=0x1234 -> with MUL_ZERO_SKIP_EN, rsp_valid at T+1 with rsp_res=0. Without the macro, rsp_valid at T+17 with rsp_res=0.

Source files
------------

// File: rtl/mul_rr_scheduler_if.sv
// Request/response bundle for the shared round-robin multiplier.
// master = clients/consumer side, slave = scheduler side.
interface mul_rr_scheduler_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_res;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_res, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_res, busy
   );
endinterface

// File: rtl/mul_rr_scheduler.sv
// Round-robin shared shift-add multiplier: one operand bit per clock.
// Optional MUL_ZERO_SKIP_EN: zero operand bypasses RUN and answers 0 immediately.
module mul_rr_scheduler #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   mul_rr_scheduler_if.slave   bus
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned PW  = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [PW-1:0]     rsp_res_q, rsp_res_d;
   logic              busy_q, busy_d;

   logic              grant_vld_c;
   logic [IDW-1:0]    grant_idx_c;
   logic [IDW:0]      scan_c;
   logic [WIDTH-1:0]  a_sel_c, b_sel_c;
   logic [PW-1:0]     acc_sum_c;

   // Scan requesters starting at the pointer, wrapping at NREQ
   always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      scan_c      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_c = (IDW+1)'(ptr_q) + (IDW+1)'(k);
         if (scan_c >= (IDW+1)'(NREQ)) scan_c = scan_c - (IDW+1)'(NREQ);
         if (!grant_vld_c && bus.req_valid[scan_c[IDW-1:0]]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = scan_c[IDW-1:0];
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE && grant_vld_c)
                        ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx_c) : '0;

   assign a_sel_c   = bus.req_a[grant_idx_c*WIDTH +: WIDTH];
   assign b_sel_c   = bus.req_b[grant_idx_c*WIDTH +: WIDTH];
   assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_res_d   = rsp_res_q;
      case (state_q)
         IDLE: begin
            if (grant_vld_c) begin
               mcand_d  = PW'(a_sel_c);
               mplier_d = b_sel_c;
               acc_d    = '0;
               cnt_d    = '0;
               id_d     = grant_idx_c;
               ptr_d    = (grant_idx_c == IDW'(NREQ-1)) ? '0 : grant_idx_c + 1'b1;
               state_d  = RUN;
`ifdef MUL_ZERO_SKIP_EN
               if (a_sel_c == '0 || b_sel_c == '0) begin
                  state_d     = DONE;
                  rsp_valid_d = 1'b1;
                  rsp_res_d   = '0;
               end
`endif
            end
         end
         RUN: begin
            acc_d    = acc_sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               rsp_res_d   = acc_sum_c;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_res_q   <= rsp_res_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_id    = id_q;
   assign bus.busy      = busy_q;
endmodule
